// File: rtl/sobol_gen.sv
// sobol_gen: single-dimension Sobol generator (Antonov-Saleev Gray-code form)
// Ports: cfg_* direction-table load, start/num_points run control,
//        busy/done status, valid_out/ready_in/u_out sample stream in [0,1).
package fpga_cfg_pkg;
   localparam int FP_WIDTH = 32;
   localparam int FP_QINT  = 15;
   localparam int FP_QFRAC = 16;
endpackage

module sobol_gen
   import fpga_cfg_pkg::*;
#(
   parameter int WIDTH      = FP_WIDTH,
   parameter int QINT       = FP_QINT,
   parameter int QFRAC      = FP_QFRAC,
   parameter int SOBOL_BITS = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_we,
   input  logic [4:0]                  cfg_addr,
   input  logic [SOBOL_BITS-1:0]       cfg_data,
   input  logic                        start,
   input  logic [CNT_WIDTH-1:0]        num_points,
   output logic                        busy,
   output logic                        done,
   output logic                        valid_out,
   input  logic                        ready_in,
   output logic signed [WIDTH-1:0]     u_out
);

   localparam int IW = (CNT_WIDTH > SOBOL_BITS) ? CNT_WIDTH : SOBOL_BITS;
   localparam int CW = $clog2(SOBOL_BITS);

   generate
      if (QFRAC > SOBOL_BITS || QFRAC >= WIDTH || QINT + QFRAC >= WIDTH) begin : g_bad_cfg
         $error("sobol_gen: output format does not fit");
      end
   endgenerate

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state_q, state_d;
   logic [SOBOL_BITS-1:0] v_q [SOBOL_BITS];
   logic [SOBOL_BITS-1:0] v_d [SOBOL_BITS];
   logic [SOBOL_BITS-1:0] x_q, x_d;
   logic [IW-1:0]         i_q, i_d;
   logic [IW-1:0]         n_q, n_d;
   logic                  done_q, done_d;
   logic [IW-1:0]         n_max, n_req;
   logic [CW-1:0]         c;
   logic                  wr_en;

   assign wr_en = cfg_we && (state_q == IDLE) && (int'(cfg_addr) < SOBOL_BITS);

   // Requested length clamped to the period of the sequence.
   always_comb begin
      n_max = '0;
      for (int k = 0; k < SOBOL_BITS; k++) n_max[k] = 1'b1;
      n_req = IW'(num_points);
      if (n_req > n_max) n_req = n_max;
   end

   // Position of the lowest zero bit of i selects the direction number.
   always_comb begin
      c = '0;
      for (int k = SOBOL_BITS - 1; k >= 0; k--) begin
         if (!i_q[k]) c = CW'(k);
      end
   end

   // Table write lands before a same-cycle start, so v_d feeds x.
   always_comb begin
      v_d = v_q;
      if (wr_en) v_d[cfg_addr] = cfg_data;
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      i_d     = i_q;
      n_d     = n_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               n_d = n_req;
               if (n_req == '0) begin
                  done_d = 1'b1;
               end else begin
                  i_d     = IW'(1);
                  x_d     = v_d[0];
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (ready_in) begin
               if (i_q < n_q) begin
                  i_d = i_q + IW'(1);
                  x_d = x_q ^ v_q[c];
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         i_q     <= '0;
         n_q     <= '0;
         done_q  <= 1'b0;
         for (int k = 0; k < SOBOL_BITS; k++) begin
            v_q[k] <= SOBOL_BITS'(1) << (SOBOL_BITS - 1 - k);
         end
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         i_q     <= i_d;
         n_q     <= n_d;
         done_q  <= done_d;
         for (int k = 0; k < SOBOL_BITS; k++) v_q[k] <= v_d[k];
      end
   end

   assign busy      = (state_q == RUN);
   assign valid_out = (state_q == RUN);
   assign done      = done_q;
   assign u_out     = {{(WIDTH - QFRAC){1'b0}}, x_q[SOBOL_BITS-1 -: QFRAC]};

endmodule

// File: tb/tb_sobol_gen.sv
// tb_sobol_gen: directed bench for sobol_gen with a queue scoreboard
// Ports: none; drives the stream with steady and random ready_in.
module tb_sobol_gen;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cfg_we;
   logic [4:0]         cfg_addr;
   logic [31:0]        cfg_data;
   logic               start;
   logic [31:0]        num_points;
   logic               busy;
   logic               done;
   logic               valid_out;
   logic               ready_in;
   logic signed [31:0] u_out;

   sobol_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .start      (start),
      .num_points (num_points),
      .busy       (busy),
      .done       (done),
      .valid_out  (valid_out),
      .ready_in   (ready_in),
      .u_out      (u_out)
   );

   always #5 clk = ~clk;

   int          total  = 0;
   int          passed = 0;
   logic [31:0] sb [$];
   logic [31:0] vdc [7];
   bit          stall_prev;
   logic [31:0] stall_val;
   bit          any_valid;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic push_vdc(input int n);
      for (int k = 0; k < n; k++) sb.push_back(vdc[k]);
   endtask

   // One clock: stream checks at negedge, status sampled just after posedge.
   task automatic step(inout int hs, output bit hs_now, output bit dn);
      @(negedge clk);
      if (valid_out) any_valid = 1'b1;
      if (stall_prev && valid_out) chk("stall_hold", u_out, stall_val);
      stall_prev = valid_out && !ready_in;
      stall_val  = u_out;
      hs_now     = valid_out && ready_in;
      if (hs_now) begin
         hs++;
         chk("sb_has_entry", sb.size() != 0, 1);
         if (sb.size() != 0) chk("sample", u_out, sb.pop_front());
      end
      @(posedge clk);
      #1;
      dn = done;
   endtask

   task automatic run(input int n, input bit rnd, input bit mid_start,
                      input bit mid_wr, input bit chain);
      int hs;
      bit h;
      bit dn;
      bit last_h;
      hs         = 0;
      dn         = 1'b0;
      any_valid  = 1'b0;
      stall_prev = 1'b0;
      num_points = n;
      start      = 1'b1;
      ready_in   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(hs, h, dn);
      start = 1'b0;
      chk("start_valid", valid_out, n > 0);
      chk("start_busy", busy, n > 0);
      last_h = h;
      for (int c = 0; c < 200 && !dn; c++) begin
         ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start    = mid_start && (c == 3);
         cfg_we   = mid_wr && (c == 1);
         cfg_addr = 5'd0;
         cfg_data = 32'h1234_5678;
         step(hs, h, dn);
         last_h = h;
      end
      start    = 1'b0;
      cfg_we   = 1'b0;
      ready_in = 1'b1;
      chk("done_seen", dn, 1);
      chk("count", hs, n);
      chk("sb_drained", sb.size(), 0);
      if (dn) begin
         chk("done_valid", valid_out, 0);
         chk("done_busy", busy, 0);
         if (n > 0) chk("done_after_last", last_h, 1);
         else chk("zero_no_valid", any_valid, 0);
      end
      if (chain) begin
         num_points = 7;
         start      = 1'b1;
      end else begin
         step(hs, h, dn);
         chk("done_fall", dn, 0);
      end
   endtask

   task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   initial begin
      int hs;
      bit h;
      bit dn;
      vdc = '{32'h8000, 32'hC000, 32'h4000, 32'h6000,
              32'hE000, 32'hA000, 32'h2000};
      rst_n      = 1'b0;
      cfg_we     = 1'b0;
      cfg_addr   = '0;
      cfg_data   = '0;
      start      = 1'b0;
      num_points = '0;
      ready_in   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_u", u_out, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      push_vdc(7);
      run(7, 0, 0, 0, 0);
      push_vdc(7);
      run(7, 1, 0, 0, 0);
      run(0, 0, 0, 0, 0);
      push_vdc(7);
      run(7, 0, 1, 0, 0);
      push_vdc(7);
      run(7, 0, 0, 0, 1);
      push_vdc(7);
      run(7, 1, 0, 0, 0);

      hs         = 0;
      stall_prev = 1'b0;
      push_vdc(7);
      num_points = 7;
      start      = 1'b1;
      ready_in   = 1'b1;
      step(hs, h, dn);
      start = 1'b0;
      for (int k = 0; k < 3; k++) step(hs, h, dn);
      chk("pre_rst_count", hs, 3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", valid_out, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_u", u_out, 0);
      sb.delete();
      for (int k = 0; k < 2; k++) begin
         step(hs, h, dn);
         chk("rst_no_done", dn, 0);
      end
      rst_n = 1'b1;
      step(hs, h, dn);
      chk("post_rst_done", dn, 0);
      push_vdc(7);
      run(7, 0, 0, 0, 0);

      cfg_wr(5'd0, 32'hC000_0000);
      cfg_wr(5'd1, 32'h4000_0000);
      sb.push_back(32'hC000);
      sb.push_back(32'h8000);
      run(2, 0, 0, 1, 0);
      sb.push_back(32'hC000);
      sb.push_back(32'h8000);
      run(2, 1, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sobol_gen.md
# sobol_gen

Single-dimension Sobol low-discrepancy generator that produces the uniform samples `u` in [0,1) consumed by the inverse-CDF stage, which turns them into z-scores. It uses the Antonov–Saleev Gray-code recurrence over a run-time loadable direction-number table. It emits a programmed number of points per run on a valid/ready stream. Index 0 (u = 0) is never emitted, so the downstream inverse CDF never sees an infinite tail.

## Interface
- `WIDTH`, `fpga_cfg_pkg::FP_WIDTH`: width of the signed fixed-point output word.
- `QINT`, `fpga_cfg_pkg::FP_QINT`: integer bits of the output format.
- `QFRAC`, `fpga_cfg_pkg::FP_QFRAC`: fractional bits of the output format. Must satisfy QFRAC ≤ SOBOL_BITS and QFRAC < WIDTH.
- `SOBOL_BITS`, 32: width of the Sobol state and of each direction number.
- `CNT_WIDTH`, 32: width of the point counter.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cfg_we`, in, 1: write strobe for the direction table.
- `cfg_addr`, in, 5: direction-table index.
- `cfg_data`, in, SOBOL_BITS: direction number v[cfg_addr].
- `start`, in, 1: one-cycle run request.
- `num_points`, in, CNT_WIDTH: number of points to emit. Sampled when `start` is accepted.
- `busy`, out, 1: high while a run is in progress.
- `done`, out, 1: one-cycle pulse when a run completes.
- `valid_out`, out, 1: `u_out` holds a valid sample.
- `ready_in`, in, 1: the downstream stage accepts the sample.
- `u_out`, out, signed WIDTH: sample in [0,1).

## Operation
- States: IDLE, RUN.
- Direction table: v[0..SOBOL_BITS-1].
  - Reset value: v[k] = 1 << (SOBOL_BITS-1-k), which gives the van der Corput sequence.
  - A write occurs when `cfg_we` is high, the block is in IDLE, and `cfg_addr` < SOBOL_BITS.
  - Writes are ignored in RUN or when `cfg_addr` is out of range.
  - A write and a `start` in the same cycle are both accepted; the write lands first.
- Start handling:
  - `start` in IDLE latches N = min(`num_points`, 2^SOBOL_BITS − 1).
  - It sets the index register i = 1 and x = v[0], then enters RUN.
  - If N = 0, the block stays in IDLE and pulses `done` the next cycle.
  - `start` in RUN is ignored.
- Recurrence: x_{i+1} = x_i XOR v[c], where c is the position of the lowest 0 bit of i. c is computed by a combinational priority encoder.
- Output format: `u_out` = zero-extend(x[SOBOL_BITS-1 -: QFRAC]). The sign bit and integer bits are always 0. Lower state bits are truncated, with no rounding.
- Stream protocol:
  - In RUN, `valid_out` = 1 and `u_out` shows sample i.
  - On a handshake (`valid_out` && `ready_in`):
    - If i < N, the block advances to i+1 and the new x appears the next cycle.
    - If i = N, the block goes to IDLE, `valid_out` falls, and `done` pulses.
  - Without a handshake, x, i and `u_out` hold stable.
- `busy` = (state == RUN).

## Timing
- Reset values: `busy` = 0, `done` = 0, `valid_out` = 0, `u_out` = 0, state = IDLE, x = 0, i = 0, table = van der Corput defaults.
- Reset asserted mid-run aborts the run immediately; no `done` pulse is issued.
- Start to first output: `start` accepted at edge t gives `valid_out` = 1 with sample 1 from edge t+1.
- Throughput: one sample per cycle while `ready_in` is held high, with no bubbles between consecutive samples.
- Last sample: a handshake at edge t gives `valid_out` = 0, `busy` = 0 and `done` = 1 during cycle t+1. `done` returns to 0 at t+2. A new `start` is accepted in the cycle where `done` = 1.
- `ready_in` does not combinationally affect `valid_out` or `u_out`; every output is a register output.
- The `u_out` value on the bus equals the x register (sample i) at all times; there is no extra output delay.

## Test plan
- Reset, then default table, QFRAC = 16, `start` with N = 7 and `ready_in` = 1:
  - `u_out` sequence must be 0x8000, 0xC000, 0x4000, 0x6000, 0xE000, 0xA000, 0x2000 on 7 consecutive cycles.
  - `done` pulses one cycle after the 7th sample, and `busy` falls at the same time.
- Backpressure: same run with `ready_in` toggled pseudo-randomly.
  - The same 7-value sequence must appear with no loss or duplication.
  - `u_out` must stay stable while `valid_out` && !`ready_in`.
- Table load: in IDLE, write v[0] = 0xC0000000 and v[1] = 0x40000000, then run N = 2.
  - Samples must be 0xC000, then 0x8000 (0xC0000000 XOR 0x40000000 = 0x80000000).
  - A write issued during RUN must leave the next run unchanged.
- `num_points` = 0: `done` pulses on the next cycle, and `valid_out`/`busy` stay 0 throughout.
- Start collisions:
  - `start` pulsed mid-run is ignored and the sample count still equals N.
  - `start` in the `done` cycle begins a new run on the next cycle, restarting at 0x8000.
- Reset mid-run: assert `rst_n` = 0 after 3 samples.
  - All outputs go to 0 immediately and no `done` pulse is issued.
  - A new run restarts at 0x8000.
